wb_trace_fifo: RTL

Writeback trace buffer that sits directly downstream of `riscv_pipeline` and consumes its writeback port (`wb_e`/`wb_a`/`wb_d`) plus the PC of the retiring instruction. Every architecturally visible register write (rd ≠ x0) is queued as a trace record and drained through a valid/ready interface to a bench monitor or host link. The `dump` strobe freezes capture so the queue can be drained without new entries arriving. Overflow and retire counters support self-checking benches.

---
 rtl/wb_trace_fifo.sv | 121 ++++++++++++
 1 files changed

// File: rtl/wb_trace_fifo.sv
// Writeback trace buffer: queues rd!=x0 writebacks as {pc, rd, data} records; head visible the cycle after capture.
// Drains over out_valid/out_ready; when full without a same-edge pop, records are dropped and counted.
module wb_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wb_e,
  input  logic [4:0]                 wb_a,
  input  logic [31:0]                wb_d,
  input  logic [31:0]                wb_pc,
  input  logic                       dump,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [4:0]                 out_a,
  output logic [31:0]                out_d,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       frozen,
  output logic [CNT_W-1:0]           retire_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  a;
    logic [31:0] d;
  } rec_t;

  typedef enum logic {CAPTURE = 1'b0, FROZEN = 1'b1} state_t;

  state_t state_q, state_d;
  logic   capture_en;

  rec_t          mem_q [DEPTH];
  rec_t          wb_rec;
  rec_t          out_rec_q, out_rec_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          out_valid_q, out_valid_d;
  logic          overflow_q, overflow_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d, drop_cnt_q, drop_cnt_d;
  logic          qualify, full, push, pop, drop;
  logic [AW:0]   count_d;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= CAPTURE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == CAPTURE && dump) state_d = FROZEN;
  end

  // dump gates capture on the very edge it is first sampled
  always_comb begin
    frozen     = (state_q == FROZEN);
    capture_en = (state_q == CAPTURE) && !dump;
  end

  assign wb_rec  = '{pc: wb_pc, a: wb_a, d: wb_d};
  assign qualify = capture_en && wb_e && (wb_a != 5'd0);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = out_valid_q && out_ready;
  assign push    = qualify && (!full || pop);
  assign drop    = qualify && full && !pop;

  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    count_d      = wr_ptr_d - rd_ptr_d;
    out_valid_d  = (count_d != '0);
    overflow_d   = overflow_q || drop;
    retire_cnt_d = retire_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    if (qualify && retire_cnt_q != '1) retire_cnt_d = retire_cnt_q + CNT_W'(1);
    if (drop && drop_cnt_q != '1)      drop_cnt_d   = drop_cnt_q + CNT_W'(1);
    // Head register preloads the next head; bypass when this edge writes that slot
    out_rec_d = out_rec_q;
    if (out_valid_d) begin
      if (push && wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]) out_rec_d = wb_rec;
      else                                              out_rec_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      retire_cnt_q <= '0;
      drop_cnt_q   <= '0;
      out_rec_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      out_valid_q  <= out_valid_d;
      overflow_q   <= overflow_d;
      retire_cnt_q <= retire_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      out_rec_q    <= out_rec_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wb_rec;
  end

  assign out_valid  = out_valid_q;
  assign out_pc     = out_rec_q.pc;
  assign out_a      = out_rec_q.a;
  assign out_d      = out_rec_q.d;
  assign count      = wr_ptr_q - rd_ptr_q;
  assign overflow   = overflow_q;
  assign retire_cnt = retire_cnt_q;
  assign drop_cnt   = drop_cnt_q;
endmodule
